gcd_requester: RTL and testbench

- Initiator side of the GCD 4-phase req/ack operand protocol: accepts an operand pair from local logic on a single-cycle start strobe.
- Serialises A then B onto the shared AB bus, waits for the result handshake, captures C and reports completion.
- Sits between a host/controller and the gcd responder block; one transaction in flight at a time.

---
 rtl/gcd_requester_if.sv | 12 +
 rtl/gcd_requester.sv | 110 +++++++++++
 tb/tb_gcd_requester.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gcd_requester_if.sv
// Operand/result handshake bundle between the GCD requester (master) and responder (slave).
interface gcd_requester_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic [WIDTH-1:0] AB;
    logic             ack;
    logic [WIDTH-1:0] C;

    modport master (output req, AB, input ack, C);
    modport slave  (input req, AB, output ack, C);
endinterface

// File: rtl/gcd_requester.sv
// GCD requester: serialises A then B over a 4-phase req/ack bus and captures C.
// Optional watchdog per wait state enabled by defining GCD_REQ_TIMEOUT_EN.
module gcd_requester #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    gcd_requester_if.master  prot
);
    typedef enum logic [2:0] {IDLE, SEND_A, REL_A, SEND_B, REL_B} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept, zero_op, timeout;

    assign accept  = (state == IDLE) && start;
    // A zero operand would stall the responder forever, so it is resolved locally.
    assign zero_op = (op_a == '0) || (op_b == '0);

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;
    logic             level_met;

    always_comb begin
        level_met = 1'b0;
        case (state)
            SEND_A, SEND_B: level_met = prot.ack;
            REL_A, REL_B:   level_met = !prot.ack;
            default:        level_met = 1'b0;
        endcase
    end

    // Abort on the cycle the counter would reach TIMEOUT_CYCLES-1 without progress.
    assign timeout = (state != IDLE) && !level_met && (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else if (state != IDLE)      cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        err <= 1'b0;
        else if (accept)  err <= 1'b0;
        else if (timeout) err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !zero_op) state_nxt = SEND_A;
            SEND_A:  if (prot.ack)          state_nxt = REL_A;
            REL_A:   if (!prot.ack)         state_nxt = SEND_B;
            SEND_B:  if (prot.ack)          state_nxt = REL_B;
            REL_B:   if (!prot.ack)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    // AB stays on the operand through the release phase; responder samples until req drops.
    always_comb begin
        prot.req = 1'b0;
        prot.AB  = '0;
        busy     = (state != IDLE);
        case (state)
            SEND_A:  begin prot.req = 1'b1; prot.AB = a_q; end
            REL_A:   prot.AB = a_q;
            SEND_B:  begin prot.req = 1'b1; prot.AB = b_q; end
            REL_B:   prot.AB = b_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (accept && zero_op) || ((state == REL_B) && !prot.ack) || timeout;
            if (accept) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            if (accept && zero_op)                result <= op_a | op_b;
            else if (timeout)                     result <= '0;
            else if ((state == SEND_B) && prot.ack) result <= prot.C;
        end
    end
endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a clocked responder model on the req/ack bus.
module tb_gcd_requester;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, err;
    logic [W-1:0] result;

    gcd_requester_if #(.WIDTH(W)) prot ();

    gcd_requester #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .prot   (prot.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int           rs;
    int           dc;
    int           resp_dly = 0;
    bit           resp_en = 1'b1;
    logic [W-1:0] seen_a, seen_b;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Responder model: ack after resp_dly cycles of req, drop ack once req falls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rs <= 0; dc <= 0; prot.ack <= 1'b0; prot.C <= '0;
            seen_a <= '0; seen_b <= '0;
        end else begin
            case (rs)
                0, 2: if (prot.req && resp_en) begin
                    if (dc < resp_dly) dc <= dc + 1;
                    else begin
                        dc <= 0;
                        prot.ack <= 1'b1;
                        if (rs == 0) seen_a <= prot.AB;
                        else begin
                            seen_b <= prot.AB;
                            prot.C <= gcd_f(seen_a, prot.AB);
                        end
                        rs <= rs + 1;
                    end
                end
                1, 3: if (!prot.req) begin
                    prot.ack <= 1'b0;
                    prot.C   <= '0;
                    rs       <= (rs == 3) ? 0 : 2;
                end
                default: rs <= 0;
            endcase
        end
    end

    int   rel_a_bad = 0;
    int   req_early = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        if (!req_prev && prot.req && prot.ack) req_early++;
        if (rs == 1 && !prot.req && prot.AB !== seen_a) rel_a_bad++;
        req_prev = prot.req;
    end

    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch,
                       output int ndone, output int first, output logic [W-1:0] res,
                       output logic bsy_done, output logic err_done, output logic bsy_after,
                       output int reqhi);
        ndone = 0; first = -1; res = '0; bsy_done = 1'b1; err_done = 1'b0; reqhi = 0;
        @(negedge clk); op_a = a; op_b = b; start = 1'b1;
        @(negedge clk); start = 1'b0; op_a = '1; op_b = '1; bsy_after = busy;
        for (int i = 0; i < 60; i++) begin
            if (i == glitch) begin op_a = 9; op_b = 3; start = 1'b1; end
            else start = 1'b0;
            if (prot.req) reqhi++;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i; res = result; bsy_done = busy; err_done = err;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int nd, fi, rh, ra0, re0;
    logic [W-1:0] rv;
    logic bd, ed, ba;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (prot.req !== 1'b0 || prot.AB !== '0) begin errors++; $display("FAIL reset_bus: req=%b AB=%0d expected 0/0", prot.req, prot.AB); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b err=%b expected 0", busy, done, err); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        txn(48, 18, -1, nd, fi, rv, bd, ed, ba, rh);
        checks++; if (rv !== 16'd6) begin errors++; $display("FAIL basic_result: got %0d expected 6", rv); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", bd); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b expected 1", ba); end
        checks++; if (seen_a !== 16'd48 || seen_b !== 16'd18) begin errors++; $display("FAIL basic_ab_seq: got %0d,%0d expected 48,18", seen_a, seen_b); end
        checks++; if (ed !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", ed); end
    endtask

    task automatic test_equal();
        ra0 = rel_a_bad; re0 = req_early; resp_dly = 2;
        txn(7, 7, -1, nd, fi, rv, bd, ed, ba, rh);
        resp_dly = 0;
        checks++; if (rv !== 16'd7) begin errors++; $display("FAIL equal_result: got %0d expected 7", rv); end
        checks++; if (rel_a_bad - ra0 !== 0) begin errors++; $display("FAIL equal_ab_hold: got %0d bad cycles expected 0", rel_a_bad - ra0); end
        checks++; if (req_early - re0 !== 0) begin errors++; $display("FAIL equal_req_early: got %0d expected 0", req_early - re0); end
    endtask

    task automatic test_zero();
        txn(0, 25, -1, nd, fi, rv, bd, ed, ba, rh);
        checks++; if (rv !== 16'd25) begin errors++; $display("FAIL zero_result: got %0d expected 25", rv); end
        checks++; if (fi !== 0) begin errors++; $display("FAIL zero_latency: done at %0d expected 0", fi); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL zero_req: req high %0d cycles expected 0", rh); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", nd); end
        txn(0, 0, -1, nd, fi, rv, bd, ed, ba, rh);
        checks++; if (rv !== 16'd0) begin errors++; $display("FAIL zero_zero_result: got %0d expected 0", rv); end
        checks++; if (fi !== 0 || rh !== 0) begin errors++; $display("FAIL zero_zero_timing: done at %0d req %0d expected 0/0", fi, rh); end
    endtask

    task automatic test_busy_ignore();
        txn(48, 18, 3, nd, fi, rv, bd, ed, ba, rh);
        checks++; if (rv !== 16'd6) begin errors++; $display("FAIL busy_ignore_result: got %0d expected 6", rv); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_ignore_done_count: got %0d expected 1", nd); end
        checks++; if (seen_b !== 16'd18) begin errors++; $display("FAIL busy_ignore_b: got %0d expected 18", seen_b); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        resp_dly = 3;
        @(negedge clk); op_a = 1071; op_b = 462; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (rs == 2 && prot.req) hit = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL reset_mid_reach_send_b: got 0 expected 1"); end
        reset = 1'b1;
        #1;
        checks++; if (prot.req !== 1'b0 || prot.AB !== '0) begin errors++; $display("FAIL reset_mid_bus: req=%b AB=%0d expected 0/0", prot.req, prot.AB); end
        checks++; if (busy !== 1'b0 || result !== '0) begin errors++; $display("FAIL reset_mid_state: busy=%b result=%0d expected 0/0", busy, result); end
        @(negedge clk); reset = 1'b0; resp_dly = 0;
        txn(1071, 462, -1, nd, fi, rv, bd, ed, ba, rh);
        checks++; if (rv !== 16'd21) begin errors++; $display("FAIL reset_mid_after: got %0d expected 21", rv); end
    endtask

`ifdef GCD_REQ_TIMEOUT_EN
    task automatic test_timeout();
        resp_en = 1'b0;
        txn(5, 3, -1, nd, fi, rv, bd, ed, ba, rh);
        resp_en = 1'b1;
        checks++; if (rh !== 15) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 15", rh); end
        checks++; if (nd !== 1 || ed !== 1'b1 || bd !== 1'b0) begin errors++; $display("FAIL timeout_flags: done=%0d err=%b busy=%b expected 1/1/0", nd, ed, bd); end
        checks++; if (rv !== 16'd0) begin errors++; $display("FAIL timeout_result: got %0d expected 0", rv); end
        txn(5, 3, -1, nd, fi, rv, bd, ed, ba, rh);
        checks++; if (rv !== 16'd1 || ed !== 1'b0) begin errors++; $display("FAIL timeout_recover: result=%0d err=%b expected 1/0", rv, ed); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_equal();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
`ifdef GCD_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
